// File: rtl/pmt_pkg.sv
// Shared types and defaults for the PMT bin UART transmitter.
package pmt_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 115200;

  // Clocks per UART bit, rounded to the nearest integer.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/bin_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured bin counts.
module bin_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // A pop frees a slot at the same edge, so a push while full is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pmt_bin_uart_tx.sv
// Captures bin counts into a FIFO and streams them as 8N1 UART bytes.
module pmt_bin_uart_tx
  import pmt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD),
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  bin_count,
  input  logic                        bin_strobe,
  input  logic                        enable,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  drop_count
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic       push, pop, drop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_term;

  assign push      = bin_strobe & enable;
  assign drop      = push & fifo_full & ~pop;
  assign baud_term = (baud_q == BAUD_LAST);
  assign uart_tx   = tx_q;
  assign busy      = (state_q != IDLE);

  bin_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (bin_count),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Drop accounting: sticky flag and saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Transmitter state; the line is registered so it never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state, FIFO pop and next line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_term) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_term) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_term) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the state being entered; shift_d[0] is the next data bit.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pmt_bin_uart_tx.sv
// Directed self-checking bench for pmt_bin_uart_tx (short bit time for run length).
module tb_pmt_bin_uart_tx;

  localparam int CPB   = 40;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bin_count = '0;
  logic       bin_strobe = 1'b0;
  logic       enable = 1'b1;
  logic       uart_tx, busy, overflow;
  logic [4:0] fifo_level;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];
  int         rx_cyc_q[$];

  pmt_bin_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .bin_count  (bin_count),
    .bin_strobe (bin_strobe),
    .enable     (enable),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bin_strobe = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int limit, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  // Line receiver: samples each bit mid-cell after a start edge.
  initial begin
    logic [7:0] b;
    int         st;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst_n === 1'b1) begin
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        rx_stop_q.push_back(uart_tx);
        rx_cyc_q.push_back(st);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    logic [7:0] exp_byte;
    int         peak;
    int         found;

    // Reset state
    @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 with exact frame timing
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    exp_byte = 8'hA5;
    bin_count = exp_byte;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    check("s_level1", fifo_level, 1);
    check("s_tx_idle", uart_tx, 1);
    @(negedge clk);
    check("s_start", uart_tx, 0);
    check("s_busy", busy, 1);
    check("s_level0", fifo_level, 0);
    repeat (CPB - 1) @(negedge clk);
    check("s_start_end", uart_tx, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("s_bit%0d_first", i), uart_tx, exp_byte[i]);
      repeat (CPB - 1) @(negedge clk);
      check($sformatf("s_bit%0d_last", i), uart_tx, exp_byte[i]);
    end
    @(negedge clk);
    check("s_stop_first", uart_tx, 1);
    repeat (CPB - 1) @(negedge clk);
    check("s_stop_last", uart_tx, 1);
    check("s_busy_last", busy, 1);
    @(negedge clk);
    check("s_busy_done", busy, 0);
    check("s_level_done", fifo_level, 0);
    check("s_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) check("s_rx_byte", rx_q[0], 8'hA5);

    // Burst of five back-to-back strobes
    repeat (5) @(negedge clk);
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      bin_count = 8'(i + 1);
      bin_strobe = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bin_strobe = 1'b0;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    check("b_peak", peak, 4);
    wait_rx(5, 6 * FRAME, "b_rx_cnt");
    if (rx_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("b_byte%0d", i), rx_q[i], i + 1);
        check($sformatf("b_stop%0d", i), rx_stop_q[i], 1);
      end
      for (int i = 0; i < 4; i++)
        check($sformatf("b_gap%0d", i), rx_cyc_q[i+1] - rx_cyc_q[i], FRAME);
    end

    // Overflow: 20 strobes, then 300 more to saturate
    repeat (FRAME) @(negedge clk);
    do_reset();
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 17) check("o_ovf_before", overflow, 0);
      bin_count = 8'(8'h40 + i);
      bin_strobe = 1'b1;
    end
    @(negedge clk);
    bin_strobe = 1'b0;
    check("o_ovf", overflow, 1);
    check("o_drops3", drop_count, 3);
    check("o_level", fifo_level, 16);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bin_count = 8'hEE;
      bin_strobe = 1'b1;
    end
    @(negedge clk);
    bin_strobe = 1'b0;
    check("o_drops_sat", drop_count, 255);
    wait_rx(17, 18 * FRAME, "o_rx_cnt");
    repeat (FRAME) @(negedge clk);
    check("o_rx_total", rx_q.size(), 17);
    if (rx_q.size() >= 17)
      for (int i = 0; i < 17; i++) check($sformatf("o_byte%0d", i), rx_q[i], 8'h40 + i);

    // Push and pop in the same cycle while full
    do_reset();
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bin_count = 8'(8'h80 + i);
      bin_strobe = 1'b1;
    end
    @(negedge clk);
    bin_strobe = 1'b0;
    check("f_level_full", fifo_level, 16);
    check("f_drops0", drop_count, 0);
    found = 0;
    for (int k = 0; k < 2 * FRAME && found == 0; k++) begin
      @(negedge clk);
      if (busy == 1'b0) found = 1;
    end
    check("f_idle_seen", found, 1);
    bin_count = 8'hC3;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    check("f_level_pp", fifo_level, 16);
    check("f_drops_pp", drop_count, 0);
    check("f_busy_pp", busy, 1);
    bin_count = 8'hDD;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    check("f_drop1", drop_count, 1);
    check("f_ovf1", overflow, 1);
    wait_rx(18, 19 * FRAME, "f_rx_cnt");
    if (rx_q.size() >= 18) begin
      check("f_byte16", rx_q[16], 8'h90);
      check("f_byte17", rx_q[17], 8'hC3);
    end

    // Enable gating
    repeat (FRAME) @(negedge clk);
    do_reset();
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bin_count = 8'h11;
      bin_strobe = 1'b1;
    end
    @(negedge clk);
    bin_strobe = 1'b0;
    check("e_level0", fifo_level, 0);
    check("e_busy0", busy, 0);
    repeat (3) @(negedge clk);
    check("e_tx_high", uart_tx, 1);
    enable = 1'b1;
    bin_count = 8'h3C;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("e_busy_mid", busy, 1);
    enable = 1'b0;
    bin_count = 8'h77;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    check("e_level_gated", fifo_level, 0);
    wait_rx(1, 2 * FRAME, "e_rx_cnt");
    if (rx_q.size() >= 1) begin
      check("e_byte", rx_q[0], 8'h3C);
      check("e_stop", rx_stop_q[0], 1);
    end
    repeat (FRAME) @(negedge clk);
    check("e_busy_end", busy, 0);
    check("e_rx_total", rx_q.size(), 1);

    // Reset in the middle of a frame
    enable = 1'b1;
    @(negedge clk);
    bin_count = 8'h00;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_count = 8'h55;
    @(negedge clk);
    bin_strobe = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("r_tx_data_low", uart_tx, 0);
    check("r_level_pre", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    check("r_tx", uart_tx, 1);
    check("r_busy", busy, 0);
    check("r_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("r_idle_after", busy, 0);
    rx_q.delete(); rx_stop_q.delete(); rx_cyc_q.delete();
    bin_count = 8'h96;
    bin_strobe = 1'b1;
    @(negedge clk);
    bin_strobe = 1'b0;
    wait_rx(1, 2 * FRAME, "r_rx_cnt");
    if (rx_q.size() >= 1) begin
      check("r_byte", rx_q[0], 8'h96);
      check("r_stop", rx_stop_q[0], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
